// File: rtl/pac_motion.sv
// Pacman position/direction/animation state, updated once per video frame.
// Buttons are synchronised; all outputs are registered and change only after frame_tick.
module pac_motion #(
  parameter int SPRITE_SCALE = 2,
  parameter int SPEED        = 2,
  parameter int START_X      = 320,
  parameter int START_Y      = 240,
  parameter int NUM_FRAMES   = 3,
  parameter int ANIM_DIV     = 4,
  parameter int UP           = 0,
  parameter int DOWN         = 1,
  parameter int LEFT         = 2,
  parameter int RIGHT        = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  output logic signed [10:0] x_Pac,
  output logic signed [10:0] y_Pac,
  output logic [1:0]         pac_Direction,
  output logic [2:0]         pac_Frame,
  output logic               moving
);

  localparam int HALF = 8 * SPRITE_SCALE;
  localparam int AW   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam logic signed [11:0] XMIN  = 12'(HALF - 1);
  localparam logic signed [11:0] XMAX  = 12'(639 - HALF);
  localparam logic signed [11:0] YMIN  = 12'(HALF - 1);
  localparam logic signed [11:0] YMAX  = 12'(479 - HALF);
  localparam logic signed [11:0] STEP  = 12'(SPEED);

  localparam logic [1:0] D_UP    = 2'(UP);
  localparam logic [1:0] D_DOWN  = 2'(DOWN);
  localparam logic [1:0] D_LEFT  = 2'(LEFT);
  localparam logic [1:0] D_RIGHT = 2'(RIGHT);

  typedef enum logic {STOPPED, MOVING} state_t;

  state_t            state_q, state_d;
  logic [3:0]        meta_q, sync_q;
  logic signed [10:0] x_q, x_d, y_q, y_d;
  logic [1:0]        dir_q, dir_d;
  logic [2:0]        frame_q, frame_d;
  logic [AW-1:0]     anim_q, anim_d;

  logic              request;
  logic [1:0]        newDir;
  logic signed [11:0] xWide, yWide, xTgt, yTgt;
  logic              atBound, hitBound;

  // Bit order in the synchroniser: {up, down, left, right}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= '0;
      sync_q  <= '0;
      state_q <= STOPPED;
      x_q     <= 11'(START_X);
      y_q     <= 11'(START_Y);
      dir_q   <= D_RIGHT;
      frame_q <= '0;
      anim_q  <= '0;
    end else begin
      meta_q  <= {btn_up, btn_down, btn_left, btn_right};
      sync_q  <= meta_q;
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      frame_q <= frame_d;
      anim_q  <= anim_d;
    end
  end

  // Direction select, clamped target, and whether the move is blocked or ends on a bound
  always_comb begin
    request  = |sync_q;
    newDir   = dir_q;
    if (sync_q[3])      newDir = D_UP;
    else if (sync_q[2]) newDir = D_DOWN;
    else if (sync_q[1]) newDir = D_LEFT;
    else if (sync_q[0]) newDir = D_RIGHT;

    xWide    = {x_q[10], x_q};
    yWide    = {y_q[10], y_q};
    xTgt     = xWide;
    yTgt     = yWide;
    atBound  = 1'b0;
    hitBound = 1'b0;
    if (newDir == D_UP) begin
      yTgt     = yWide - STEP;
      if (yTgt < YMIN) yTgt = YMIN;
      atBound  = (yWide <= YMIN);
      hitBound = (yTgt == YMIN);
    end else if (newDir == D_DOWN) begin
      yTgt     = yWide + STEP;
      if (yTgt > YMAX) yTgt = YMAX;
      atBound  = (yWide >= YMAX);
      hitBound = (yTgt == YMAX);
    end else if (newDir == D_LEFT) begin
      xTgt     = xWide - STEP;
      if (xTgt < XMIN) xTgt = XMIN;
      atBound  = (xWide <= XMIN);
      hitBound = (xTgt == XMIN);
    end else begin
      xTgt     = xWide + STEP;
      if (xTgt > XMAX) xTgt = XMAX;
      atBound  = (xWide >= XMAX);
      hitBound = (xTgt == XMAX);
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    frame_d = frame_q;
    anim_d  = anim_q;
    if (frame_tick) begin
      if (state_q == MOVING || (request && !atBound)) begin
        dir_d = newDir;
        x_d   = xTgt[10:0];
        y_d   = yTgt[10:0];
        if (state_q == MOVING && hitBound) begin
          state_d = STOPPED;
          frame_d = '0;
          anim_d  = '0;
        end else begin
          state_d = MOVING;
          if (anim_q == AW'(ANIM_DIV - 1)) begin
            anim_d  = '0;
            frame_d = (frame_q == 3'(NUM_FRAMES - 1)) ? 3'd0 : frame_q + 3'd1;
          end else begin
            anim_d = anim_q + AW'(1);
          end
        end
      end else if (request) begin
        dir_d = newDir;
      end
    end
  end

  assign x_Pac         = x_q;
  assign y_Pac         = y_q;
  assign pac_Direction = dir_q;
  assign pac_Frame     = frame_q;
  assign moving        = (state_q == MOVING);

endmodule

// File: tb/tb_pac_motion.sv
// Directed self-checking bench for pac_motion with default parameters.
module tb_pac_motion;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic signed [10:0] x_Pac, y_Pac;
  logic [1:0] pac_Direction;
  logic [2:0] pac_Frame;
  logic moving;

  int compared = 0;
  int mismatched = 0;

  pac_motion dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .x_Pac(x_Pac), .y_Pac(y_Pac), .pac_Direction(pac_Direction),
    .pac_Frame(pac_Frame), .moving(moving)
  );

  always #5 clk = ~clk;

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0;
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    waitCycles(3);
    compared++;
    if (x_Pac !== 11'sd320 || y_Pac !== 11'sd240 || pac_Direction !== 2'd3 ||
        pac_Frame !== 3'd0 || moving !== 1'b0) begin
      $display("[TB] FAIL reset_state: got x=%0d y=%0d dir=%0d frame=%0d mv=%0b, want 320 240 3 0 0",
               x_Pac, y_Pac, pac_Direction, pac_Frame, moving);
      mismatched++;
    end
    rst_n = 1'b1;
    waitCycles(1);
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++;
      if (x_Pac !== 11'sd320 || y_Pac !== 11'sd240 || pac_Direction !== 2'd3 ||
          pac_Frame !== 3'd0 || moving !== 1'b0) begin
        $display("[TB] FAIL idle_tick%0d: got x=%0d y=%0d dir=%0d frame=%0d mv=%0b, want 320 240 3 0 0",
                 i, x_Pac, y_Pac, pac_Direction, pac_Frame, moving);
        mismatched++;
      end
    end
  endtask

  task automatic test_move_right();
    btn_right = 1'b1;
    waitCycles(3);
    compared++;
    if (x_Pac !== 11'sd320 || moving !== 1'b0) begin
      $display("[TB] FAIL no_move_before_tick: got x=%0d mv=%0b, want 320 0", x_Pac, moving);
      mismatched++;
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      compared++;
      if (x_Pac !== 11'(320 + 2 * k) || y_Pac !== 11'sd240 || moving !== 1'b1 ||
          pac_Frame !== ((k == 4) ? 3'd1 : 3'd0) || pac_Direction !== 2'd3) begin
        $display("[TB] FAIL move_right%0d: got x=%0d y=%0d mv=%0b frame=%0d dir=%0d, want %0d 240 1 %0d 3",
                 k, x_Pac, y_Pac, moving, pac_Frame, pac_Direction, 320 + 2 * k, (k == 4) ? 1 : 0);
        mismatched++;
      end
    end
  endtask

  task automatic test_right_bound();
    int expX;
    bit expMv;
    btn_right = 1'b0;
    waitCycles(3);
    expX = 328;
    for (int i = 0; i < 149; i++) begin
      tick();
      expX = expX + 2;
      if (expX > 623) expX = 623;
      expMv = (expX != 623);
      compared++;
      if (x_Pac !== 11'(expX) || moving !== expMv || pac_Frame >= 3'd3 ||
          (!expMv && pac_Frame !== 3'd0)) begin
        $display("[TB] FAIL right_run%0d: got x=%0d mv=%0b frame=%0d, want x=%0d mv=%0b",
                 i, x_Pac, moving, pac_Frame, expX, expMv);
        mismatched++;
      end
    end
    btn_right = 1'b1;
    waitCycles(3);
    for (int i = 0; i < 2; i++) begin
      tick();
      compared++;
      if (x_Pac !== 11'sd623 || moving !== 1'b0 || pac_Frame !== 3'd0 || pac_Direction !== 2'd3) begin
        $display("[TB] FAIL right_blocked%0d: got x=%0d mv=%0b frame=%0d dir=%0d, want 623 0 0 3",
                 i, x_Pac, moving, pac_Frame, pac_Direction);
        mismatched++;
      end
    end
    btn_right = 1'b0;
  endtask

  task automatic test_priority();
    doReset();
    btn_up = 1'b1;
    btn_left = 1'b1;
    waitCycles(3);
    tick();
    compared++;
    if (pac_Direction !== 2'd0 || y_Pac !== 11'sd238 || x_Pac !== 11'sd320 || moving !== 1'b1) begin
      $display("[TB] FAIL priority_up_left: got dir=%0d x=%0d y=%0d mv=%0b, want 0 320 238 1",
               pac_Direction, x_Pac, y_Pac, moving);
      mismatched++;
    end
    btn_up = 1'b0;
    btn_left = 1'b0;
  endtask

  task automatic test_left_bound();
    doReset();
    btn_left = 1'b1;
    waitCycles(3);
    tick();
    btn_left = 1'b0;
    waitCycles(3);
    repeat (151) tick();
    compared++;
    if (x_Pac !== 11'sd16 || moving !== 1'b1 || pac_Direction !== 2'd2) begin
      $display("[TB] FAIL left_at16: got x=%0d mv=%0b dir=%0d, want 16 1 2", x_Pac, moving, pac_Direction);
      mismatched++;
    end
    tick();
    compared++;
    if (x_Pac !== 11'sd15 || moving !== 1'b0 || pac_Frame !== 3'd0 || y_Pac !== 11'sd240) begin
      $display("[TB] FAIL left_clamp: got x=%0d mv=%0b frame=%0d y=%0d, want 15 0 0 240",
               x_Pac, moving, pac_Frame, y_Pac);
      mismatched++;
    end
  endtask

  task automatic test_reversal_and_async_reset();
    doReset();
    btn_right = 1'b1;
    waitCycles(3);
    tick();
    btn_right = 1'b0;
    btn_left = 1'b1;
    waitCycles(3);
    tick();
    compared++;
    if (x_Pac !== 11'sd320 || pac_Direction !== 2'd2 || moving !== 1'b1) begin
      $display("[TB] FAIL reversal: got x=%0d dir=%0d mv=%0b, want 320 2 1", x_Pac, pac_Direction, moving);
      mismatched++;
    end
    tick();
    compared++;
    if (x_Pac !== 11'sd318 || moving !== 1'b1) begin
      $display("[TB] FAIL pre_reset_move: got x=%0d mv=%0b, want 318 1", x_Pac, moving);
      mismatched++;
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (x_Pac !== 11'sd320 || y_Pac !== 11'sd240 || pac_Direction !== 2'd3 ||
        pac_Frame !== 3'd0 || moving !== 1'b0) begin
      $display("[TB] FAIL async_reset: got x=%0d y=%0d dir=%0d frame=%0d mv=%0b, want 320 240 3 0 0",
               x_Pac, y_Pac, pac_Direction, pac_Frame, moving);
      mismatched++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (x_Pac !== 11'sd320 || pac_Direction !== 2'd3 || moving !== 1'b0) begin
        $display("[TB] FAIL tick_in_reset%0d: got x=%0d dir=%0d mv=%0b, want 320 3 0",
                 i, x_Pac, pac_Direction, moving);
        mismatched++;
      end
    end
    btn_left = 1'b0;
    rst_n = 1'b1;
    waitCycles(1);
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_right_bound();
    test_priority();
    test_left_bound();
    test_reversal_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pac_motion.md
Name: pac_motion

Overview:
- Sequential stage directly upstream of the pixel colour chooser.
- Synchronises the four direction buttons and updates Pacman's centre position (x_Pac, y_Pac), facing direction and animation frame once per video frame.
- Outputs are registered and change only just after frame_tick, so the colour chooser never sees a position change mid-frame.

Parameters:
- SPRITE_SCALE, 2, sprite magnification; half-extent HALF = 8*SPRITE_SCALE.
- SPEED, 2, pixels moved per frame_tick while moving (1..HALF).
- START_X, 320, reset x centre.
- START_Y, 240, reset y centre.
- NUM_FRAMES, 3, animation frames cycled (1..8).
- ANIM_DIV, 4, frame_ticks per animation step (>=1).
- UP, 0, direction code.
- DOWN, 1, direction code.
- LEFT, 2, direction code.
- RIGHT, 3, direction code.

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame (start of vertical blank)
- btn_up, btn_down, btn_left, btn_right  in  1 each  raw asynchronous buttons, active-high
- x_Pac  out  11 signed  sprite centre x
- y_Pac  out  11 signed  sprite centre y
- pac_Direction  out  2  facing direction code
- pac_Frame  out  3  animation frame index
- moving  out  1  1 = state MOVING

Behaviour:
- Reset (async on rst_n low, held until release):
  - x_Pac=START_X, y_Pac=START_Y, pac_Direction=RIGHT, pac_Frame=0, moving=0.
  - State STOPPED, anim counter 0, synchroniser flops 0.
- Button synchronisation:
  - Each button passes through a 2-flop synchroniser.
  - Only synchronised values are used, sampled in the frame_tick cycle.
- Legal bounds, derived so the drawn sprite pixels (centre-HALF, centre+HALF] stay on screen:
  - XMIN = HALF-1, XMAX = 639-HALF.
  - YMIN = HALF-1, YMAX = 479-HALF.
  - Defaults: x in [15,623], y in [15,463].
- All state and output updates occur only in a cycle where frame_tick=1. Outputs take their new values on the following clock edge (1-cycle latency). Between ticks, everything holds.
- On a tick, the following steps occur in order, all within one update:
  - 1. Direction select: if any synchronised button is high, new_dir = highest priority pressed (UP > DOWN > LEFT > RIGHT), and request=1. Otherwise new_dir = pac_Direction and request=0.
  - 2. Target: pos + SPEED along new_dir. Up is y-SPEED, down y+SPEED, left x-SPEED, right x+SPEED. Use 12-bit signed intermediates, then clamp to [MIN,MAX] on the moved axis. The other axis is unchanged.
  - 3. State transitions:
    - STOPPED with request=0: no change.
    - STOPPED with request=1: pac_Direction<=new_dir. If the position is already at the bound in new_dir, stay STOPPED with position unchanged. Otherwise go to MOVING and apply the target position in this same tick.
    - MOVING: pac_Direction<=new_dir and apply the target position. If the clamped result equals the bound in new_dir, go to STOPPED. Otherwise stay MOVING.
  - Movement with no button held continues in the current direction until a bound is reached.
  - 4. Animation:
    - In MOVING after the update: anim counter increments; when it reaches ANIM_DIV-1 it returns to 0 and pac_Frame <= (pac_Frame+1) mod NUM_FRAMES.
    - On entering STOPPED: pac_Frame<=0 and anim counter <=0.
- A reversal (e.g. RIGHT to LEFT) takes effect on a single tick; no intermediate stop.
- Simultaneous buttons: resolved by priority, never by combination; there is no diagonal movement.
- A frame_tick while rst_n is low is ignored. If reset asserts mid-movement, all values return to reset immediately.
- pac_Direction is always one of the four parameter codes. pac_Frame is always < NUM_FRAMES.

Test Plan:
- Reset then release, no buttons, 5 ticks -> x=320, y=240, dir=RIGHT, frame=0, moving=0 throughout.
- btn_right held through the synchroniser, then 1 tick -> next cycle x=322, moving=1. After a further 3 ticks -> x=328, and pac_Frame steps to 1 on the 4th moving tick (ANIM_DIV=4).
- Right press, then release; run ticks -> x climbs by 2 per tick to 623 and clamps there (never 624). moving=0 and frame=0 on the tick that reaches 623. Further btn_right presses leave x=623 and moving=0.
- btn_up and btn_left both held from STOPPED at (320,240), 1 tick -> dir=UP, y=238, x=320.
- Start at (16,240) moving LEFT, SPEED=2, 1 tick -> x=15 (clamped from 14), moving=0.
- While moving, assert rst_n low asynchronously mid-cycle -> outputs read (320,240,RIGHT,0,0) before the next clk edge. Ticks during reset cause no change.
